// File: rtl/turnstile_pkg.sv
// rtl/turnstile_pkg.sv - shared types and constants for the turnstile validation arbiter
package turnstile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_CODE_W = 4;

  // Window of codes the validator accepts; used by validator models.
  localparam int CODE_MIN = 4;
  localparam int CODE_MAX = 11;

  function automatic logic code_in_window(input logic [DEF_CODE_W-1:0] code);
    return (int'(code) >= CODE_MIN) && (int'(code) <= CODE_MAX);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first requester at or after ptr
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[(int'(ptr) + i) % N]) begin
        any                          = 1'b1;
        idx                          = IDX_W'((int'(ptr) + i) % N);
        grant[(int'(ptr) + i) % N]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/turnstile_validation_arbiter.sv
// rtl/turnstile_validation_arbiter.sv - shares one code validator among several card readers
module turnstile_validation_arbiter
  import turnstile_pkg::*;
#(
  parameter int NUM_READERS    = 4,
  parameter int CODE_W         = DEF_CODE_W,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int CNT_W          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_READERS-1:0]        rd_req,
  input  logic [NUM_READERS*CODE_W-1:0] rd_code,
  output logic [NUM_READERS-1:0]        rd_done,
  output logic                          rd_grant,
  output logic [CODE_W-1:0]             val_code,
  output logic                          val_start,
  input  logic                          val_busy,
  input  logic                          val_done,
  input  logic                          val_grant,
  output logic [CNT_W-1:0]              grant_cnt,
  output logic [CNT_W-1:0]              deny_cnt,
  output logic [CNT_W-1:0]              timeout_cnt
);

  localparam int IDX_W = $clog2(NUM_READERS);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [CODE_W-1:0]  code_q;
  logic [TMR_W-1:0]   timer_q;
  logic               verdict_q;

  logic [NUM_READERS-1:0] arb_grant;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_any;
  logic                   select;
  logic                   timeout_hit;

  rr_arbiter #(
    .N     (NUM_READERS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req   (rd_req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign select      = (state == IDLE) && !val_busy && arb_any;
  // A verdict arriving on the last timer cycle takes precedence over the timeout.
  assign timeout_hit = (state == WAIT) && !val_done &&
                       (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (select) state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (val_done || timeout_hit) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      code_q    <= '0;
      ptr_q     <= '0;
      timer_q   <= '0;
      verdict_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (select) begin
            idx_q  <= arb_idx;
            code_q <= rd_code[arb_idx*CODE_W +: CODE_W];
          end
        end
        ISSUE: begin
          timer_q   <= '0;
          verdict_q <= 1'b0;
        end
        WAIT: begin
          if (val_done) begin
            verdict_q <= val_grant;
          end else if (timeout_hit) begin
            verdict_q <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RESP: begin
          ptr_q <= (idx_q == IDX_W'(NUM_READERS - 1)) ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt   <= '0;
      deny_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      if (timeout_hit) begin
        timeout_cnt <= sat_inc(timeout_cnt);
      end
      if (state == RESP) begin
        if (verdict_q) begin
          grant_cnt <= sat_inc(grant_cnt);
        end else begin
          deny_cnt  <= sat_inc(deny_cnt);
        end
      end
    end
  end

  assign val_start = (state == ISSUE);
  assign val_code  = code_q;
  assign rd_done   = (state == RESP) ? (NUM_READERS'(1) << idx_q) : '0;
  assign rd_grant  = (state == RESP) && verdict_q;

endmodule

// File: tb/tb_turnstile_validation_arbiter.sv
// tb/tb_turnstile_validation_arbiter.sv - directed self-checking bench for turnstile_validation_arbiter
module tb_turnstile_validation_arbiter;
  import turnstile_pkg::*;

  localparam int N  = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    rd_req;
  logic [N*CW-1:0] rd_code;
  logic [N-1:0]    rd_done;
  logic            rd_grant;
  logic [CW-1:0]   val_code;
  logic            val_start;
  logic            val_busy;
  logic            val_done;
  logic            val_grant;
  logic [15:0]     grant_cnt;
  logic [15:0]     deny_cnt;
  logic [15:0]     timeout_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int start_cnt   = 0;

  turnstile_validation_arbiter #(
    .NUM_READERS    (N),
    .CODE_W         (CW),
    .TIMEOUT_CYCLES (32),
    .CNT_W          (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_req      (rd_req),
    .rd_code     (rd_code),
    .rd_done     (rd_done),
    .rd_grant    (rd_grant),
    .val_code    (val_code),
    .val_start   (val_start),
    .val_busy    (val_busy),
    .val_done    (val_done),
    .val_grant   (val_grant),
    .grant_cnt   (grant_cnt),
    .deny_cnt    (deny_cnt),
    .timeout_cnt (timeout_cnt)
  );

  always #5 clk = ~clk;

  always begin
    @(negedge clk);
    #2;
    if (val_start) start_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [3:0] c);
    rd_req[r]             = 1'b1;
    rd_code[r*CW +: CW]   = c;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!val_start && n < 60);
  endtask

  // Validator model: answers delay cycles after val_start when answer=1.
  task automatic finish_txn(input int delay, input bit answer,
                            output logic [3:0] done, output logic gr, output int lat);
    done = '0;
    gr   = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (rd_done != '0) begin
        done = rd_done;
        gr   = rd_grant;
        lat  = c;
        break;
      end
      if (answer && c == delay) begin
        val_done  = 1'b1;
        val_grant = code_in_window(val_code);
      end else begin
        val_done  = 1'b0;
        val_grant = 1'b0;
      end
    end
    val_done  = 1'b0;
    val_grant = 1'b0;
  endtask

  logic [3:0] done;
  logic       gr;
  int         lat;
  int         n;
  int         s0;
  int         extra;
  logic [3:0] codes [4];
  int         ord   [5];

  initial begin
    codes = '{4'd5, 4'd6, 4'd7, 4'd8};
    ord   = '{0, 1, 2, 3, 0};
    rst = 1'b1; rd_req = '0; rd_code = '0;
    val_busy = 1'b0; val_done = 1'b0; val_grant = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_done",   32'(rd_done),     32'd0);
    check("rst_rd_grant",  32'(rd_grant),    32'd0);
    check("rst_val_start", 32'(val_start),   32'd0);
    check("rst_val_code",  32'(val_code),    32'd0);
    check("rst_grant_cnt", 32'(grant_cnt),   32'd0);
    check("rst_deny_cnt",  32'(deny_cnt),    32'd0);
    check("rst_tmo_cnt",   32'(timeout_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // reader 2, code 9, granted 3 cycles after val_start
    set_req(2, 4'd9);
    wait_start(n);
    check("t1_start_lat", 32'(n), 32'd1);
    check("t1_val_code", 32'(val_code), 32'd9);
    finish_txn(3, 1'b1, done, gr, lat);
    check("t1_rd_done", 32'(done), 32'h4);
    check("t1_rd_grant", 32'(gr), 32'd1);
    check("t1_done_lat", 32'(lat), 32'd4);
    rd_req[2] = 1'b0;
    @(negedge clk);
    check("t1_grant_cnt", 32'(grant_cnt), 32'd1);
    check("t1_deny_cnt", 32'(deny_cnt), 32'd0);

    // all four readers; reader 0 keeps requesting
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int r = 0; r < N; r++) set_req(r, codes[r]);
    s0 = start_cnt;
    for (int k = 0; k < 5; k++) begin
      wait_start(n);
      check("t2_val_code", 32'(val_code), 32'(codes[ord[k]]));
      finish_txn(2, 1'b1, done, gr, lat);
      check("t2_rd_done", 32'(done), 32'(4'b0001 << ord[k]));
      check("t2_rd_grant", 32'(gr), 32'd1);
      if (ord[k] != 0 || k == 4) rd_req[ord[k]] = 1'b0;
    end
    @(negedge clk);
    check("t2_start_count", 32'(start_cnt - s0), 32'd5);
    check("t2_grant_cnt", 32'(grant_cnt), 32'd5);

    // reader 1, code 2 outside the window -> deny
    set_req(1, 4'd2);
    wait_start(n);
    finish_txn(2, 1'b1, done, gr, lat);
    check("t3_rd_done", 32'(done), 32'h2);
    check("t3_rd_grant", 32'(gr), 32'd0);
    rd_req[1] = 1'b0;
    @(negedge clk);
    check("t3_deny_cnt", 32'(deny_cnt), 32'd1);
    check("t3_grant_cnt", 32'(grant_cnt), 32'd5);

    // stray val_done while idle
    val_done = 1'b1; val_grant = 1'b1;
    @(negedge clk);
    val_done = 1'b0; val_grant = 1'b0;
    @(negedge clk);
    check("idle_vd_rd_done", 32'(rd_done), 32'd0);
    check("idle_vd_grant_cnt", 32'(grant_cnt), 32'd5);
    check("idle_vd_deny_cnt", 32'(deny_cnt), 32'd1);

    // no verdict at all -> timeout deny
    set_req(3, 4'd9);
    wait_start(n);
    finish_txn(0, 1'b0, done, gr, lat);
    check("t4_rd_done", 32'(done), 32'h8);
    check("t4_rd_grant", 32'(gr), 32'd0);
    check("t4_done_lat", 32'(lat), 32'd33);
    rd_req[3] = 1'b0;
    @(negedge clk);
    check("t4_tmo_cnt", 32'(timeout_cnt), 32'd1);
    check("t4_deny_cnt", 32'(deny_cnt), 32'd2);

    // verdict on the last timer cycle beats the timeout
    set_req(0, 4'd9);
    wait_start(n);
    finish_txn(32, 1'b1, done, gr, lat);
    check("t4b_rd_done", 32'(done), 32'h1);
    check("t4b_rd_grant", 32'(gr), 32'd1);
    check("t4b_done_lat", 32'(lat), 32'd33);
    rd_req[0] = 1'b0;
    @(negedge clk);
    check("t4b_tmo_cnt", 32'(timeout_cnt), 32'd1);
    check("t4b_grant_cnt", 32'(grant_cnt), 32'd6);

    // validator busy for 20 cycles
    val_busy = 1'b1;
    set_req(0, 4'd7);
    s0 = start_cnt;
    repeat (20) @(negedge clk);
    check("t5_no_start_busy", 32'(start_cnt - s0), 32'd0);
    val_busy = 1'b0;
    @(negedge clk);
    check("t5_start_after_busy", 32'(val_start), 32'd1);
    finish_txn(1, 1'b1, done, gr, lat);
    check("t5_rd_done", 32'(done), 32'h1);
    check("t5_rd_grant", 32'(gr), 32'd1);
    check("t5_done_lat", 32'(lat), 32'd2);
    rd_req[0] = 1'b0;
    @(negedge clk);
    check("t5_grant_cnt", 32'(grant_cnt), 32'd7);

    // reset during WAIT
    set_req(2, 4'd10);
    wait_start(n);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rd_done", 32'(rd_done), 32'd0);
    check("t6_rd_grant", 32'(rd_grant), 32'd0);
    check("t6_val_start", 32'(val_start), 32'd0);
    check("t6_val_code", 32'(val_code), 32'd0);
    check("t6_grant_cnt", 32'(grant_cnt), 32'd0);
    check("t6_tmo_cnt", 32'(timeout_cnt), 32'd0);
    rd_req[2] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rd_done != '0) extra++;
    end
    check("t6_no_done_after_rst", 32'(extra), 32'd0);

    set_req(1, 4'd4);
    wait_start(n);
    check("t6_start_lat", 32'(n), 32'd1);
    check("t6_val_code_min", 32'(val_code), 32'd4);
    finish_txn(2, 1'b1, done, gr, lat);
    check("t6_new_rd_done", 32'(done), 32'h2);
    check("t6_new_rd_grant", 32'(gr), 32'd1);
    rd_req[1] = 1'b0;

    set_req(3, 4'd12);
    wait_start(n);
    finish_txn(2, 1'b1, done, gr, lat);
    check("t6_hi_rd_done", 32'(done), 32'h8);
    check("t6_hi_rd_grant", 32'(gr), 32'd0);
    rd_req[3] = 1'b0;
    @(negedge clk);
    check("t6_grant_cnt_end", 32'(grant_cnt), 32'd1);
    check("t6_deny_cnt_end", 32'(deny_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
